// File: rtl/viterbi_pkg.sv
// Shared definitions for the soft-decision K=3 Viterbi decoder.
//   N_STATES  : trellis states (state = {newest input, previous input})
//   N_BRANCH  : distinct branch registers {u, s[1], s[0]}
//   G0_DEF/G1_DEF : default generator polynomials (7/5 octal)
//   fsm_t     : frame-control states
//   enc_bits  : expected {code bit 1, code bit 0} for input u leaving state st
package viterbi_pkg;

  localparam int unsigned N_STATES = 4;
  localparam int unsigned N_BRANCH = 8;
  localparam logic [2:0]  G0_DEF   = 3'b111;
  localparam logic [2:0]  G1_DEF   = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fsm_t;

  function automatic logic [1:0] enc_bits(input logic       u,
                                          input logic [1:0] st,
                                          input logic [2:0] g0 = G0_DEF,
                                          input logic [2:0] g1 = G1_DEF);
    logic [2:0] r;
    r = {u, st};
    return {^(r & g1), ^(r & g0)};
  endfunction

endpackage

// File: rtl/soft_bmu.sv
// Soft-decision branch metric unit (combinational).
//   in_sym0/in_sym1 : soft values, 0 = strong '0', all-ones = strong '1'
//   bm[r]           : metric of branch register r = {u, s[1], s[0]},
//                     sum of the distances of both symbols to the expected code bits
module soft_bmu
  import viterbi_pkg::*;
#(
  parameter int unsigned SOFT_W = 3,
  parameter logic [2:0]  G0     = G0_DEF,
  parameter logic [2:0]  G1     = G1_DEF
) (
  input  logic [SOFT_W-1:0]               in_sym0,
  input  logic [SOFT_W-1:0]               in_sym1,
  output logic [N_BRANCH-1:0][SOFT_W:0]   bm
);

  localparam logic [SOFT_W-1:0] SOFT_MAX = '1;

  logic [2:0]        r;
  logic [1:0]        code;
  logic [SOFT_W-1:0] cost0;
  logic [SOFT_W-1:0] cost1;

  always_comb begin
    bm    = '0;
    r     = '0;
    code  = '0;
    cost0 = '0;
    cost1 = '0;
    for (int unsigned i = 0; i < N_BRANCH; i++) begin
      r     = 3'(i);
      code  = enc_bits(r[2], r[1:0], G0, G1);
      cost0 = code[0] ? (SOFT_MAX - in_sym0) : in_sym0;
      cost1 = code[1] ? (SOFT_MAX - in_sym1) : in_sym1;
      bm[i] = {1'b0, cost0} + {1'b0, cost1};
    end
  end

endmodule

// File: rtl/viterbi_soft_decoder.sv
// Streaming rate-1/2 K=3 soft-decision Viterbi decoder with register-exchange
// survivors and framed operation (sop/eop) including end-of-frame flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : soft symbol pair handshake
//   in_sym0/in_sym1     : soft values for code bits 0 and 1
//   in_sop/in_eop       : first/last symbol of a frame (qualified by accept)
//   out_valid/out_ready : decoded bit handshake
//   out_bit/out_last    : decoded bit, marks the final bit of a frame
//   busy                : decoder is inside a frame (state != IDLE)
module viterbi_soft_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned SOFT_W   = 3,
  parameter int unsigned PM_W     = 8,
  parameter int unsigned TB_DEPTH = 16,
  parameter logic [2:0]  G0       = G0_DEF,
  parameter logic [2:0]  G1       = G1_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SOFT_W-1:0] in_sym0,
  input  logic [SOFT_W-1:0] in_sym1,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned BM_W  = SOFT_W + 1;
  localparam int unsigned PMX_W = PM_W + 1;
  localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(TB_DEPTH);
  localparam logic [PM_W-1:0]  PM_HALF = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [N_STATES-1:0][PM_W-1:0] PM_INIT =
    {{(N_STATES-1){PM_HALF}}, {PM_W{1'b0}}};

  fsm_t                               state_q, state_d;
  logic [N_STATES-1:0][PM_W-1:0]      pm_q, pm_cur, pm_new;
  logic [N_STATES-1:0][TB_DEPTH-1:0]  path_q, path_cur, path_new;
  logic [TB_DEPTH-1:0]                flush_q;
  logic [CNT_W-1:0]                   k_q, k_cur, k_new, rem_q, rem_new;
  logic [IDX_W-1:0]                   rem_idx;
  logic [N_BRANCH-1:0][BM_W-1:0]      bm;
  logic [N_STATES-1:0][PMX_W-1:0]     win;
  logic [N_STATES-1:0]                dec;
  logic [PMX_W-1:0]                   c0, c1, win_min, diff;
  logic [1:0]                         sp, p0, p1, best;
  logic                               accept, frame_init, emit, flush_go;

  soft_bmu #(
    .SOFT_W (SOFT_W),
    .G0     (G0),
    .G1     (G1)
  ) u_bmu (
    .in_sym0 (in_sym0),
    .in_sym1 (in_sym1),
    .bm      (bm)
  );

  assign in_ready   = rst_n & (state_q != FLUSH) & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  // A symbol accepted in IDLE always starts a frame, with or without sop.
  assign frame_init = accept & (in_sop | (state_q == IDLE));
  assign k_cur      = frame_init ? '0 : k_q;
  assign k_new      = (k_cur == DEPTH) ? DEPTH : k_cur + CNT_W'(1);
  assign emit       = accept & (k_new == DEPTH);
  // k_new never exceeds the depth, so it already equals min(k_new, depth).
  assign rem_new    = k_new - CNT_W'(emit);
  assign flush_go   = (state_q == FLUSH) & (~out_valid | out_ready);
  assign rem_idx    = IDX_W'(rem_q - CNT_W'(1));
  assign busy       = (state_q != IDLE);

  // ACS with frame initialisation applied ahead of the current symbol,
  // normalisation against the smallest survivor, and register exchange.
  always_comb begin
    pm_cur   = frame_init ? PM_INIT : pm_q;
    path_cur = frame_init ? '0 : path_q;
    win      = '0;
    dec      = '0;
    path_new = '0;
    pm_new   = '0;
    c0       = '0;
    c1       = '0;
    sp       = '0;
    p0       = '0;
    p1       = '0;
    diff     = '0;
    best     = '0;
    for (int unsigned s = 0; s < N_STATES; s++) begin
      sp          = 2'(s);
      p0          = {sp[0], 1'b0};
      p1          = {sp[0], 1'b1};
      c0          = {1'b0, pm_cur[p0]} + PMX_W'(bm[{sp, 1'b0}]);
      c1          = {1'b0, pm_cur[p1]} + PMX_W'(bm[{sp, 1'b1}]);
      dec[s]      = (c1 < c0);
      win[s]      = dec[s] ? c1 : c0;
      path_new[s] = {path_cur[dec[s] ? p1 : p0][TB_DEPTH-2:0], sp[1]};
    end
    win_min = win[0];
    for (int unsigned s = 1; s < N_STATES; s++) begin
      if (win[s] < win_min) win_min = win[s];
    end
    for (int unsigned s = 0; s < N_STATES; s++) begin
      diff      = win[s] - win_min;
      pm_new[s] = diff[PM_W] ? '1 : diff[PM_W-1:0];
    end
    for (int unsigned s = 1; s < N_STATES; s++) begin
      if (pm_new[s] < pm_new[best]) best = 2'(s);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (in_eop) state_d = (rem_new == '0) ? IDLE : FLUSH;
          else        state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_go && (rem_q == CNT_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pm_q      <= PM_INIT;
      path_q    <= '0;
      flush_q   <= '0;
      k_q       <= '0;
      rem_q     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pm_q   <= pm_new;
        path_q <= path_new;
        k_q    <= k_new;
        if (in_eop) begin
          flush_q <= path_new[best];
          rem_q   <= rem_new;
        end
      end
      // accept and flush_go are exclusive: in_ready is low during FLUSH.
      if (emit) begin
        out_valid <= 1'b1;
        out_bit   <= path_new[best][TB_DEPTH-1];
        out_last  <= in_eop & (rem_new == '0);
      end else if (flush_go) begin
        out_valid <= 1'b1;
        out_bit   <= flush_q[rem_idx];
        out_last  <= (rem_q == CNT_W'(1));
        rem_q     <= rem_q - CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/viterbi_soft_decoder.md
Name: viterbi_soft_decoder

Overview:
Streaming rate-1/2, K=3 (4-state) Viterbi decoder. Successor to the hard-decision fixed-depth decoder: soft-decision inputs, parametrised soft width, metric width and survivor depth, valid/ready handshakes, per-step metric normalisation, and framed operation with end-of-frame flush. It sits between the soft demapper and the descrambler.

Parameters:
SOFT_W, 3, bits per soft symbol, unsigned: 0 = strong '0', 2^SOFT_W-1 = strong '1'
PM_W, 8, path-metric width; must satisfy PM_W >= SOFT_W+3
TB_DEPTH, 16, survivor length in bits (register-exchange depth); range 4..64
G0, 3'b111, generator polynomial for code bit 0; reg = {u, s[1], s[0]}
G1, 3'b101, generator polynomial for code bit 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  soft symbol pair valid
in_ready  out  1  decoder accepts symbol pair
in_sym0  in  SOFT_W  soft value for code bit 0
in_sym1  in  SOFT_W  soft value for code bit 1
in_sop  in  1  first symbol of frame (qualified by in_valid & in_ready)
in_eop  in  1  last symbol of frame (qualified)
out_valid  out  1  decoded bit valid
out_ready  in  1  downstream accepts bit
out_bit  out  1  decoded bit
out_last  out  1  final decoded bit of frame
busy  out  1  state != IDLE

Behaviour:
- Single clock clk; async active-low reset rst_n. Reset: out_valid=0, out_bit=0, out_last=0, busy=0, in_ready=0 while rst_n low, FSM=IDLE, PMs as frame init, path registers and counters 0.
- Accept = in_valid & in_ready. in_ready = (FSM != FLUSH) & (!out_valid | out_ready).
- State s = {newest input, previous input}. Next state = {u, s[1]}. Predecessors of s' are {s'[0],0} and {s'[0],1}; decision bit = chosen predecessor's bit 0.
- BMU (combinational): expected bit e: cost = e ? (2^SOFT_W-1 - sym) : sym. BM = cost0 + cost1, SOFT_W+1 bits.
- ACS: cand = PM[p] + BM(p->s'); select lower; tie selects predecessor {s'[0],0}. Normalise: subtract min of the 4 candidates-winners, then saturate at 2^PM_W-1.
- Frame init, on accepted in_sop (or reset): PM[0]=0, PM[1..3]=2^(PM_W-1); all paths cleared; symbol count k=0. This is applied before that symbol's ACS.
- Path update (register exchange): P[s'] = {P[pred][TB_DEPTH-2:0], s'[1]}. best = argmin new PM, ties to lowest index.
- FSM IDLE -> RUN on accepted in_sop. IDLE with accept without sop: treated as sop.
- RUN: each accept k++ (saturating at TB_DEPTH). When k reaches TB_DEPTH, each accept loads out_bit = P_new[best][TB_DEPTH-1] and sets out_valid next cycle. Latency: one clock from accept to out_valid.
- Accepted in_eop: latch F = P_new[best], R = min(k_new, TB_DEPTH) minus (1 if a RUN bit was emitted on that accept). If R == 0, mark that emitted bit as out_last and go to IDLE; else go to FLUSH.
- FLUSH: in_ready=0; each cycle with (!out_valid | out_ready) emit F[R-1], R--. out_last=1 on the bit with R==1, then IDLE. Total bits out per frame = symbols in.
- Output register holds out_bit/out_last stable while out_valid & !out_ready.
- Accepted in_sop while RUN: abort. Bits not yet emitted are discarded, the frame is re-initialised, and an already-loaded output bit still completes.
- Accepted in_sop & in_eop on the same symbol: one-symbol frame, emits 1 bit with out_last.
- Reset mid-frame or mid-flush: immediate return to reset values. No partial output afterwards.

Decomposition:
- viterbi_pkg: N_STATES=4, G0/G1 defaults, FSM enum {IDLE, RUN, FLUSH}, function enc_bits(u, state) returning the expected 2-bit code.
- One sub-module, soft_bmu: combinational, 8 branch metrics from in_sym0/in_sym1, parametrised SOFT_W.
- ACS, normalisation, register exchange, FSM and output register stay in the top.

Test Plan:
- Noiseless, defaults, 24 info bits incl. 2 zero tail, encoded (G 7/5), soft values 0/7, sop/eop -> 24 bits out equal to the input. First out_valid one clock after the 16th accept. out_last on bit 24 only.
- Same frame with 3 symbols spaced at least 6 apart set to mid value 3 or 4 -> output is still error-free.
- Same frame with one code bit hard-flipped (0<->7) -> output error-free; PMs never exceed 2^PM_W-1.
- out_ready held low 10 cycles mid-RUN -> in_ready low after the first pending bit; out_bit stable; no bits lost or duplicated.
- 5-symbol frame (sop on first, eop on fifth) -> in_ready low during flush; exactly 5 bits out, out_last on the 5th; busy returns 0.
- rst_n pulsed low during FLUSH, then a new 20-bit frame -> no out_valid until the new frame's 16th accept; new frame decodes correctly.
